// File: rtl/rom_accum_pkg.sv
// Shared definitions for the ROM window accumulator: default widths and FSM state encoding.
package rom_accum_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int SUM_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_accum_dp.sv
// Accumulator datapath: running sum with sticky carry, word counter, and optional min/max
// trackers (present only when ROM_MINMAX_EN is defined).
module rom_accum_dp
  import rom_accum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              init,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [SUM_W-1:0]  sum,
  output logic [ADDR_W:0]   count,
  output logic              ovf
`ifdef ROM_MINMAX_EN
  ,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val
`endif
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [SUM_W:0] sum_ext;

  // One extra bit catches the carry-out that feeds the sticky overflow flag.
  assign sum_ext = {1'b0, sum} + {{(SUM_W + 1 - DATA_W){1'b0}}, rom_data};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (init) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (acc_en) begin
      sum <= sum_ext[SUM_W-1:0];
      ovf <= ovf | sum_ext[SUM_W];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (init) begin
      count <= '0;
    end else if (acc_en) begin
      count <= count + CNT_ONE;
    end
  end

`ifdef ROM_MINMAX_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      min_val <= '1;
      max_val <= '0;
    end else if (init) begin
      min_val <= '1;
      max_val <= '0;
    end else if (acc_en) begin
      if (rom_data < min_val) min_val <= rom_data;
      if (rom_data > max_val) max_val <= rom_data;
    end
  end
`endif

endmodule

// File: rtl/rom_accum_ctrl.sv
// Start/busy/done sequencer that walks a ROM window and sums it via rom_accum_dp.
// Optional min/max outputs are enabled with the ROM_MINMAX_EN macro.
module rom_accum_ctrl
  import rom_accum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [ADDR_W:0]   count,
  output logic              ovf
`ifdef ROM_MINMAX_EN
  ,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count_inc;
  logic              init;
  logic              acc_en;

  assign count_inc = count + CNT_ONE;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    init      = 1'b0;
    acc_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          init      = 1'b1;
          state_nxt = (len == '0) ? ST_FIN : ST_FILL;
        end
      end
      ST_FILL: begin
        busy      = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy   = 1'b1;
        acc_en = 1'b1;
        if (count_inc == len_q) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The address runs one word ahead of the accumulator to cover the ROM read latency;
  // the final prefetch past the window is simply never added.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rom_addr <= '0;
      len_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= len;
            if (len != '0) rom_addr <= base_addr;
          end
        end
        ST_FILL, ST_RUN: rom_addr <= rom_addr + ADDR_ONE;
        default: ;
      endcase
    end
  end

  rom_accum_dp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_dp (
    .clk      (clk),
    .clr      (clr),
    .init     (init),
    .acc_en   (acc_en),
    .rom_data (rom_data),
    .sum      (sum),
    .count    (count),
    .ovf      (ovf)
`ifdef ROM_MINMAX_EN
    ,
    .min_val  (min_val),
    .max_val  (max_val)
`endif
  );

endmodule

// File: tb/tb_rom_accum_ctrl.sv
// Scoreboard bench for rom_accum_ctrl with a behavioural synchronous ROM; min/max checks
// are included when ROM_MINMAX_EN is defined.
module tb_rom_accum_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int SUM_W  = 10;

  logic              clk;
  logic              clr;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum;
  logic [ADDR_W:0]   count;
  logic              ovf;
`ifdef ROM_MINMAX_EN
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;
`endif

  typedef struct {
    int sum;
    int cnt;
    int ovf;
    int mn;
    int mx;
  } exp_t;

  exp_t        exp_q[$];
  int          addr_log[$];
  logic [7:0]  rom[16];
  int          tests_run = 0;
  int          tests_failed = 0;

  rom_accum_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .count     (count),
    .ovf       (ovf)
`ifdef ROM_MINMAX_EN
    ,
    .min_val   (min_val),
    .max_val   (max_val)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (!clr && done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", int'(done), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sum", int'(sum), e.sum);
        checkOutput("count", int'(count), e.cnt);
        checkOutput("ovf", int'(ovf), e.ovf);
`ifdef ROM_MINMAX_EN
        checkOutput("min_val", int'(min_val), e.mn);
        checkOutput("max_val", int'(max_val), e.mx);
`endif
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [3:0] base, input logic [4:0] n,
                               input int exp_sum, input int exp_cnt, input int exp_ovf,
                               input int exp_mn, input int exp_mx, input int exp_lat,
                               input int abort_at, input int repulse_at);
    exp_t e;
    int   idx;
    int   busy_cycles;
    int   lat;
    int   seen;
    if (abort_at == 0) begin
      e.sum = exp_sum;
      e.cnt = exp_cnt;
      e.ovf = exp_ovf;
      e.mn  = exp_mn;
      e.mx  = exp_mx;
      exp_q.push_back(e);
    end
    addr_log.delete();
    @(negedge clk);
    base_addr = base;
    len       = n;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    idx = 0;
    busy_cycles = 0;
    lat = 0;
    seen = 0;
    while (idx < 40) begin
      @(negedge clk);
      idx++;
      if (idx == repulse_at) begin
        start     = 1'b1;
        base_addr = 4'd8;
        len       = 5'd2;
      end else begin
        start = 1'b0;
      end
      if (busy) begin
        busy_cycles++;
        addr_log.push_back(int'(rom_addr));
      end
      if (done) begin
        lat  = idx;
        seen = 1;
        break;
      end
      if (idx == abort_at) begin
        clr = 1'b1;
        #1;
        checkOutput({name, "_clr_sum"}, int'(sum), 0);
        checkOutput({name, "_clr_count"}, int'(count), 0);
        checkOutput({name, "_clr_busy"}, int'(busy), 0);
        checkOutput({name, "_clr_addr"}, int'(rom_addr), 0);
        checkOutput({name, "_clr_ovf"}, int'(ovf), 0);
        #1 clr = 1'b0;
      end
      if (abort_at != 0 && idx >= abort_at + 6) break;
    end
    if (abort_at == 0) begin
      checkOutput({name, "_done_seen"}, seen, 1);
      checkOutput({name, "_latency"}, lat, exp_lat);
      checkOutput({name, "_busy_cycles"}, busy_cycles, exp_lat - 1);
      @(negedge clk);
      checkOutput({name, "_done_width"}, int'(done), 0);
    end else begin
      checkOutput({name, "_no_done"}, seen, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    for (int i = 0; i < 16; i++) rom[i] = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_sum", int'(sum), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_addr", int'(rom_addr), 0);
`ifdef ROM_MINMAX_EN
    checkOutput("rst_min", int'(min_val), 255);
    checkOutput("rst_max", int'(max_val), 0);
`endif
    clr = 1'b0;

    rom[0] = 8'd1; rom[1] = 8'd2; rom[2] = 8'd3; rom[3] = 8'd4;
    applyStimulus("basic", 4'd0, 5'd4, 10, 4, 0, 1, 4, 6, 0, 0);

    rom[14] = 8'd5; rom[15] = 8'd6; rom[0] = 8'd7; rom[1] = 8'd8;
    applyStimulus("wrap", 4'd14, 5'd4, 26, 4, 0, 5, 8, 6, 0, 0);
    checkOutput("wrap_addr_len", addr_log.size(), 5);
    if (addr_log.size() >= 4) begin
      checkOutput("wrap_addr0", addr_log[0], 14);
      checkOutput("wrap_addr1", addr_log[1], 15);
      checkOutput("wrap_addr2", addr_log[2], 0);
      checkOutput("wrap_addr3", addr_log[3], 1);
    end

    for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
    applyStimulus("ovf", 4'd0, 5'd16, 1008, 16, 1, 255, 255, 18, 0, 0);
    applyStimulus("len0", 4'd3, 5'd0, 0, 0, 0, 255, 0, 1, 0, 0);
    applyStimulus("ovf2", 4'd0, 5'd16, 1008, 16, 1, 255, 255, 18, 0, 0);
    applyStimulus("len1", 4'd5, 5'd1, 255, 1, 0, 255, 255, 3, 0, 0);

    for (int i = 0; i < 16; i++) rom[i] = 8'd0;
    rom[0] = 8'd1; rom[1] = 8'd2; rom[2] = 8'd3; rom[3] = 8'd4;
    rom[8] = 8'd50; rom[9] = 8'd60;
    applyStimulus("repulse", 4'd0, 5'd4, 10, 4, 0, 1, 4, 6, 0, 3);
    applyStimulus("abort", 4'd0, 5'd4, 0, 0, 0, 255, 0, 0, 3, 0);
    applyStimulus("after_abort", 4'd1, 5'd2, 5, 2, 0, 2, 3, 4, 0, 0);

    rom[0] = 8'd9; rom[1] = 8'd3; rom[2] = 8'd200; rom[3] = 8'd17;
    applyStimulus("minmax", 4'd0, 5'd4, 229, 4, 0, 3, 200, 6, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("pending_results", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rom_accum_ctrl.md
Name: rom_accum_ctrl

Overview:
Sequencer that walks a contiguous window of the data ROM, feeds each word into a running accumulator and reports the total to the 7-segment display path. It replaces free-running manual clocking of the accumulator with a start/busy/done handshake. It sits between the board control logic (button/switch synchroniser) and the ROM plus display-decoder chain.

Parameters:
ADDR_W, 4, ROM address width; the ROM holds 2^ADDR_W words.
DATA_W, 8, ROM word width.
SUM_W, 16, accumulator width; must be >= DATA_W.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
clr  in  1  reset, asynchronous, active-high.
start  in  1  request a run; sampled only in IDLE.
base_addr  in  ADDR_W  first ROM address of the window; sampled with start.
len  in  ADDR_W+1  number of words to sum, 0..2^ADDR_W; sampled with start.
rom_addr  out  ADDR_W  address to the synchronous ROM (1-cycle read latency).
rom_data  in  DATA_W  ROM output; holds the word for the address presented on the previous cycle.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when the result is final.
sum  out  SUM_W  accumulated total; held after done until the next accepted start.
count  out  ADDR_W+1  words accumulated so far.
ovf  out  1  sticky carry-out of sum; cleared at start.
min_val, max_val  out  DATA_W each  present only with ROM_MINMAX_EN.

Behaviour:
- Reset (clr=1, any time including mid-run): state=IDLE; rom_addr=0, busy=0, done=0, sum=0, count=0, ovf=0, min_val=all-ones, max_val=0. Takes effect immediately, without waiting for a clock edge.
- States: IDLE, FILL, RUN, FIN.
- IDLE: on an edge with start=1, latch base_addr and len, and set sum=0, count=0, ovf=0.
  - len=0: go to FIN.
  - Otherwise: rom_addr=base_addr, busy=1, go to FILL.
- FILL (one cycle, ROM pipeline fill): rom_addr+=1, go to RUN.
- RUN, every edge:
  - sum <= sum + zero-extended rom_data; ovf |= carry-out; count+=1.
  - rom_addr+=1.
  - When count reaches len (after the edge that adds the len-th word), go to FIN.
- FIN (one cycle): done=1, busy=0, then IDLE. sum, count and ovf hold.
- Timing: with start accepted at edge E0 and len=N>0, the final sum is visible after edge E(N+1). done is high during the cycle after E(N+1) and busy falls in that same cycle.
- rom_addr wraps modulo 2^ADDR_W. The one-word prefetch past the window is harmless and its data is discarded.
- Overflow: sum wraps modulo 2^SUM_W and ovf stays 1 until the next start.
- start while busy, or while in FIN, is ignored; no queuing.
- start held high across FIN re-triggers once IDLE is reached. This is legal back-to-back operation.

Optional Feature:
ROM_MINMAX_EN.
- Defined: min_val and max_val ports exist.
  - Both are re-initialised at start to all-ones and 0 respectively.
  - Each RUN edge updates them with rom_data.
  - Both are held after done.
  - With len=0 they stay at their initial values.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package rom_accum_pkg holds:
  - the state encoding constants ST_IDLE, ST_FILL, ST_RUN, ST_FIN;
  - the default widths.
- Sub-module rom_accum_dp is the datapath:
  - sum/ovf register with synchronous clear and enable;
  - count register;
  - optional min/max registers.
- The FSM and address generator stay in the top module.

Test Plan:
- ROM[0..3]=1,2,3,4; base=0, len=4, start pulse -> busy for 5 cycles, done pulse 6 cycles after the start edge, sum=10, count=4, ovf=0.
- base=14, len=4, ADDR_W=4, ROM[14]=5, ROM[15]=6, ROM[0]=7, ROM[1]=8 -> rom_addr sequence 14,15,0,1, sum=26.
- SUM_W=10, all ROM words 0xFF, base=0, len=16 -> sum=1008 (4080 mod 1024), ovf=1; a following start with len=1 gives ovf=0, sum=255.
- len=0 -> no FILL/RUN, done one cycle after the start edge, sum=0, busy never asserted.
- start re-pulsed mid-run -> ignored, result as for the single run; clr pulsed mid-run between edges -> outputs zero immediately, IDLE, no done pulse.
- With ROM_MINMAX_EN, data 9,3,200,17 -> min_val=3, max_val=200, sum=229.
